// File: rtl/calc_sequencer_if.sv
// ALU request/response bundle between the calculator sequencer and its ALU.
interface calc_sequencer_if #(
   parameter int unsigned OP_W  = 11,
   parameter int unsigned RES_W = 32
);
   logic             alu_valid;
   logic             alu_ready;
   logic             alu_done;
   logic [RES_W-1:0] alu_result;
   logic [9:0]       operand_a;
   logic [9:0]       operand_b;
   logic [OP_W-1:0]  alu_op;

   modport master (
      output alu_valid, operand_a, operand_b, alu_op,
      input  alu_ready, alu_done, alu_result
   );

   modport slave (
      input  alu_valid, operand_a, operand_b, alu_op,
      output alu_ready, alu_done, alu_result
   );
endinterface

// File: rtl/calc_sequencer.sv
// Button-driven BCD operand entry, one-hot op select, ALU handshake and paged result display.
// Optional macro CALC_SEQ_TIMEOUT_EN adds a WAIT timeout that lands in the ERR state.
module calc_sequencer #(
   parameter  int unsigned OP_W    = 11,
   parameter  int unsigned RES_W   = 32,
   parameter  int unsigned PAGES   = 4,
   parameter  int unsigned TIMEOUT = 1024,
   localparam int unsigned PG_W    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
   input  logic              CLK100MHZ,
   input  logic              rst_n,
   input  logic              btn_up_p,
   input  logic              btn_down_p,
   input  logic              btn_left_p,
   input  logic              btn_center_p,
   input  logic [OP_W-1:0]   op_sel,
   calc_sequencer_if.master  alu,
   output logic [3:0]        entry_digit,
   output logic [RES_W-1:0]  result,
   output logic [PG_W-1:0]   page,
   output logic [2:0]        state,
   output logic [1:0]        LED
);

   typedef enum logic [2:0] {
      ST_ENTRY_A = 3'd0,
      ST_ENTRY_B = 3'd1,
      ST_OP_SEL  = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_WAIT    = 3'd4,
      ST_SHOW    = 3'd5,
      ST_ERR     = 3'd6
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [11:0]       r_bcd_a, r_bcd_b, w_bcd_a_nxt, w_bcd_b_nxt;
   logic [3:0]        r_digit, w_digit_nxt;
   logic [OP_W-1:0]   r_op, w_op_nxt;
   logic [RES_W-1:0]  r_result, w_result_nxt;
   logic [PG_W-1:0]   r_page, w_page_nxt;
   logic              r_valid;
   logic [1:0]        r_led;
   logic              w_onehot;
   logic              w_tmo_hit;

   function automatic logic [9:0] bcd2bin(input logic [11:0] b);
      return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
   endfunction

   assign w_onehot = (op_sel != '0) && ((op_sel & (op_sel - OP_W'(1))) == '0);

`ifdef CALC_SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TMO_W-1:0] r_tmo_cnt;

   // Counts cycles spent in WAIT; cleared everywhere else
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n)                 r_tmo_cnt <= '0;
      else if (r_state == ST_WAIT) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                        r_tmo_cnt <= '0;
   end

   assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) r_state <= ST_ENTRY_A;
      else        r_state <= w_state_nxt;
   end

   // Next state and next datapath values; priority center > left > up > down
   always_comb begin
      w_state_nxt  = r_state;
      w_bcd_a_nxt  = r_bcd_a;
      w_bcd_b_nxt  = r_bcd_b;
      w_digit_nxt  = r_digit;
      w_op_nxt     = r_op;
      w_result_nxt = r_result;
      w_page_nxt   = r_page;
      unique case (r_state)
         ST_ENTRY_A, ST_ENTRY_B: begin
            if (btn_center_p) begin
               w_digit_nxt = '0;
               w_state_nxt = (r_state == ST_ENTRY_A) ? ST_ENTRY_B : ST_OP_SEL;
            end else if (btn_left_p) begin
               if (r_state == ST_ENTRY_A) w_bcd_a_nxt = {r_bcd_a[7:0], r_digit};
               else                       w_bcd_b_nxt = {r_bcd_b[7:0], r_digit};
               w_digit_nxt = '0;
            end else if (btn_up_p) begin
               w_digit_nxt = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
            end else if (btn_down_p) begin
               w_digit_nxt = (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
            end
         end
         ST_OP_SEL: begin
            if (btn_center_p && w_onehot) begin
               w_op_nxt    = op_sel;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (alu.alu_ready) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (alu.alu_done) begin
               w_result_nxt = alu.alu_result;
               w_page_nxt   = '0;
               w_state_nxt  = ST_SHOW;
            end else if (w_tmo_hit) begin
               w_state_nxt = ST_ERR;
            end
         end
         ST_SHOW: begin
            if (btn_center_p) begin
               w_bcd_a_nxt = '0;
               w_bcd_b_nxt = '0;
               w_digit_nxt = '0;
               w_op_nxt    = '0;
               w_state_nxt = ST_ENTRY_A;
            end else if (!btn_left_p) begin
               if (btn_up_p)
                  w_page_nxt = (r_page == PG_W'(PAGES - 1)) ? '0 : r_page + PG_W'(1);
               else if (btn_down_p)
                  w_page_nxt = (r_page == '0) ? PG_W'(PAGES - 1) : r_page - PG_W'(1);
            end
         end
         ST_ERR: begin
            if (btn_center_p) begin
               w_bcd_a_nxt = '0;
               w_bcd_b_nxt = '0;
               w_digit_nxt = '0;
               w_op_nxt    = '0;
               w_state_nxt = ST_ENTRY_A;
            end
         end
         default: w_state_nxt = ST_ENTRY_A;
      endcase
   end

   // Datapath and status registers; valid/LED follow the next state so they align with it
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd_a  <= '0;
         r_bcd_b  <= '0;
         r_digit  <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_page   <= '0;
         r_valid  <= 1'b0;
         r_led    <= '0;
      end else begin
         r_bcd_a  <= w_bcd_a_nxt;
         r_bcd_b  <= w_bcd_b_nxt;
         r_digit  <= w_digit_nxt;
         r_op     <= w_op_nxt;
         r_result <= w_result_nxt;
         r_page   <= w_page_nxt;
         r_valid  <= (w_state_nxt == ST_ISSUE);
         r_led[0] <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
         r_led[1] <= (w_state_nxt == ST_ERR);
      end
   end

   assign alu.alu_valid = r_valid;
   assign alu.operand_a = bcd2bin(r_bcd_a);
   assign alu.operand_b = bcd2bin(r_bcd_b);
   assign alu.alu_op    = r_op;
   assign entry_digit   = r_digit;
   assign result        = r_result;
   assign page          = r_page;
   assign state         = r_state;
   assign LED           = r_led;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: vector table for operand entry, hand sequences for handshake, paging, reset, timeout.
module tb_calc_sequencer;
   localparam int unsigned OP_W  = 11;
   localparam int unsigned RES_W = 32;
   localparam int unsigned PAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             btn_up_p, btn_down_p, btn_left_p, btn_center_p;
   logic [OP_W-1:0]  op_sel;
   logic [3:0]       entry_digit;
   logic [RES_W-1:0] result;
   logic [1:0]       page;
   logic [2:0]       state;
   logic [1:0]       LED;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   calc_sequencer_if #(.OP_W(OP_W), .RES_W(RES_W)) alu_if ();

   calc_sequencer #(.OP_W(OP_W), .RES_W(RES_W), .PAGES(PAGES), .TIMEOUT(1024)) dut (
      .CLK100MHZ    (clk),
      .rst_n        (rst_n),
      .btn_up_p     (btn_up_p),
      .btn_down_p   (btn_down_p),
      .btn_left_p   (btn_left_p),
      .btn_center_p (btn_center_p),
      .op_sel       (op_sel),
      .alu          (alu_if),
      .entry_digit  (entry_digit),
      .result       (result),
      .page         (page),
      .state        (state),
      .LED          (LED)
   );

   typedef struct {
      logic [3:0] btn;   // {center, left, up, down}
      logic [2:0] st;
      logic [3:0] dig;
      logic [9:0] opa;
      logic [9:0] opb;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] b);
      {btn_center_p, btn_left_p, btn_up_p, btn_down_p} = b;
      tick();
      {btn_center_p, btn_left_p, btn_up_p, btn_down_p} = 4'b0000;
   endtask

   task automatic goto_wait(input logic [OP_W-1:0] op);
      press(4'b1000);
      press(4'b1000);
      op_sel = op;
      press(4'b1000);
      alu_if.alu_ready = 1'b1;
      tick();
      alu_if.alu_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not end, errors so far %0d", n_err);
      $fatal(1);
   end

   initial begin
      int vcnt;
      logic [9:0] exp_b[3];
      exp_b[0] = 10'd19; exp_b[1] = 10'd199; exp_b[2] = 10'd999;

      vecs[0]  = '{4'b0000, 3'd0, 4'd0, 10'd0,   10'd0};
      vecs[1]  = '{4'b0010, 3'd0, 4'd1, 10'd0,   10'd0};
      vecs[2]  = '{4'b0001, 3'd0, 4'd0, 10'd0,   10'd0};
      vecs[3]  = '{4'b0001, 3'd0, 4'd9, 10'd0,   10'd0};
      vecs[4]  = '{4'b0010, 3'd0, 4'd0, 10'd0,   10'd0};
      vecs[5]  = '{4'b0010, 3'd0, 4'd1, 10'd0,   10'd0};
      vecs[6]  = '{4'b0010, 3'd0, 4'd2, 10'd0,   10'd0};
      vecs[7]  = '{4'b0110, 3'd0, 4'd0, 10'd2,   10'd0};
      vecs[8]  = '{4'b0001, 3'd0, 4'd9, 10'd2,   10'd0};
      vecs[9]  = '{4'b0100, 3'd0, 4'd0, 10'd29,  10'd0};
      vecs[10] = '{4'b0010, 3'd0, 4'd1, 10'd29,  10'd0};
      vecs[11] = '{4'b0100, 3'd0, 4'd0, 10'd291, 10'd0};
      vecs[12] = '{4'b0001, 3'd0, 4'd9, 10'd291, 10'd0};
      vecs[13] = '{4'b0101, 3'd0, 4'd0, 10'd919, 10'd0};
      vecs[14] = '{4'b0010, 3'd0, 4'd1, 10'd919, 10'd0};
      vecs[15] = '{4'b1110, 3'd1, 4'd0, 10'd919, 10'd0};
      vecs[16] = '{4'b0010, 3'd1, 4'd1, 10'd919, 10'd0};
      vecs[17] = '{4'b0100, 3'd1, 4'd0, 10'd919, 10'd1};

      rst_n = 1'b0;
      {btn_center_p, btn_left_p, btn_up_p, btn_down_p} = 4'b0000;
      op_sel = '0;
      alu_if.alu_ready  = 1'b0;
      alu_if.alu_done   = 1'b0;
      alu_if.alu_result = '0;
      #12;
      chk("reset state", 32'(state), 0);
      chk("reset alu_valid", 32'(alu_if.alu_valid), 0);
      chk("reset LED", 32'(LED), 0);
      chk("reset result", 32'(result), 0);
      chk("reset page", 32'(page), 0);
      chk("reset alu_op", 32'(alu_if.alu_op), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Operand A entry and the first digit of B from the vector table
      foreach (vecs[i]) begin
         press(vecs[i].btn);
         chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
         chk($sformatf("v%0d digit", i), 32'(entry_digit), 32'(vecs[i].dig));
         chk($sformatf("v%0d operand_a", i), 32'(alu_if.operand_a), 32'(vecs[i].opa));
         chk($sformatf("v%0d operand_b", i), 32'(alu_if.operand_b), 32'(vecs[i].opb));
      end

      // Operand B to 999 via nine ups and a left, three times
      for (int k = 0; k < 3; k++) begin
         repeat (9) press(4'b0010);
         press(4'b0100);
         chk($sformatf("B pass%0d operand_b", k), 32'(alu_if.operand_b), 32'(exp_b[k]));
      end
      press(4'b1000);
      chk("B center state", 32'(state), 2);
      chk("B center operand_b", 32'(alu_if.operand_b), 999);
      chk("B center digit", 32'(entry_digit), 0);

      // OP_SEL: ignored buttons and non-one-hot selects
      press(4'b0010);
      chk("opsel up digit", 32'(entry_digit), 0);
      op_sel = 11'b00000000011;
      press(4'b1000);
      chk("opsel two-hot state", 32'(state), 2);
      op_sel = 11'b00000000000;
      press(4'b1000);
      chk("opsel zero state", 32'(state), 2);
      op_sel = 11'b10000000000;
      press(4'b1000);
      chk("issue state", 32'(state), 3);
      chk("issue LED", 32'(LED), 1);
      chk("issue alu_op", 32'(alu_if.alu_op), 32'h400);

      // ISSUE held 6 cycles: ready low 5 cycles, then high; stray done ignored
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (alu_if.alu_valid === 1'b1) vcnt++;
         if (i == 4) chk("issue operand_a stable", 32'(alu_if.operand_a), 919);
         alu_if.alu_ready  = (i == 5);
         alu_if.alu_done   = (i == 2);
         alu_if.alu_result = (i == 2) ? 32'd77 : 32'd0;
         tick();
         alu_if.alu_ready = 1'b0;
         alu_if.alu_done  = 1'b0;
      end
      chk("alu_valid cycles", 32'(vcnt), 6);
      chk("wait state", 32'(state), 4);
      chk("wait alu_valid", 32'(alu_if.alu_valid), 0);
      chk("done in issue ignored", 32'(result), 0);
      press(4'b1000);
      chk("wait center ignored", 32'(state), 4);

      alu_if.alu_result = 32'd1998;
      alu_if.alu_done   = 1'b1;
      tick();
      alu_if.alu_done = 1'b0;
      chk("show state", 32'(state), 5);
      chk("show result", 32'(result), 1998);
      chk("show page", 32'(page), 0);
      chk("show LED", 32'(LED), 0);

      // Page wrapping in SHOW
      for (int i = 0; i < 5; i++) begin
         press(4'b0010);
         chk($sformatf("page up%0d", i), 32'(page), 32'((i + 1) % 4));
      end
      press(4'b0001);
      chk("page down to 0", 32'(page), 0);
      press(4'b0001);
      chk("page down wrap", 32'(page), 3);
      press(4'b0010);
      chk("page up wrap", 32'(page), 0);
      press(4'b0010);
      press(4'b1000);
      chk("clear state", 32'(state), 0);
      chk("clear operand_a", 32'(alu_if.operand_a), 0);
      chk("clear operand_b", 32'(alu_if.operand_b), 0);
      chk("clear alu_op", 32'(alu_if.alu_op), 0);
      chk("clear keeps result", 32'(result), 1998);

      // Asynchronous reset mid-WAIT, then a late alu_done
      goto_wait(11'b00000000100);
      chk("rst-run wait state", 32'(state), 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst state", 32'(state), 0);
      chk("async rst alu_valid", 32'(alu_if.alu_valid), 0);
      chk("async rst LED", 32'(LED), 0);
      chk("async rst result", 32'(result), 0);
      chk("async rst page", 32'(page), 0);
      chk("async rst alu_op", 32'(alu_if.alu_op), 0);
      @(negedge clk);
      rst_n = 1'b1;
      alu_if.alu_result = 32'd55;
      alu_if.alu_done   = 1'b1;
      tick();
      alu_if.alu_done = 1'b0;
      chk("late done state", 32'(state), 0);
      chk("late done result", 32'(result), 0);

      // WAIT with no alu_done
      goto_wait(11'b00000000001);
`ifdef CALC_SEQ_TIMEOUT_EN
      repeat (1023) tick();
      chk("timeout edge-1 state", 32'(state), 4);
      tick();
      chk("timeout state", 32'(state), 6);
      chk("timeout LED", 32'(LED), 2);
      press(4'b1000);
      chk("err clear state", 32'(state), 0);
      chk("err clear LED", 32'(LED), 0);
`else
      repeat (1100) tick();
      chk("no-timeout state", 32'(state), 4);
      chk("no-timeout LED", 32'(LED), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
